// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the two-port memory arbiter.
//   state_t  - arbiter FSM encoding
//   PORT_*   - grant index of each master
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one master's request/response channel into the arbiter.
//   valid/we/addr/wdata : request, driven by the master
//   ack/rdata/err       : one-cycle completion, driven by the arbiter
// Modports: master (requester side), slave (arbiter side).
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
);
  logic              valid;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output valid, we, addr, wdata, input  ack, rdata, err);
  modport slave  (input  valid, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: combinational two-request round-robin picker.
//   valid[1:0] - pending requests
//   last_grant - index granted most recently
//   grant      - chosen index (only meaningful when any_valid)
//   any_valid  - at least one request pending
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       any_valid
);
  assign any_valid = |valid;
  // On contention alternate away from the last winner; otherwise take whoever asks.
  assign grant = (&valid) ? ~last_grant : valid[1];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide memory port between the CPU (req0)
// and an auxiliary master (req1), one transfer at a time, round-robin.
//   clk, rst_n        - clock, async active-low reset
//   req0, req1        - master channels (mem_arbiter_if.slave)
//   mem_addr          - latched address, held until the next grant
//   mem_data_in       - latched write data, held until the next grant
//   mem_data_out      - read data from memory
//   mem_read_en       - held through READ until mem_ready or timeout
//   mem_write_en      - single-cycle write strobe
//   mem_ready         - read data valid; ignored outside READ
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_arbiter_if.slave      req0,
  mem_arbiter_if.slave      req1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_read_en,
  output logic              mem_write_en,
  input  logic              mem_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic              last_grant, gnt;
  logic              arb_gnt, any_valid;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              ack0, ack1;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              timeout_hit;

  rr_arb2 u_rr (
    .valid      ({req1.valid, req0.valid}),
    .last_grant (last_grant),
    .grant      (arb_gnt),
    .any_valid  (any_valid)
  );

  assign sel_we    = (arb_gnt == PORT_AUX) ? req1.we    : req0.we;
  assign sel_addr  = (arb_gnt == PORT_AUX) ? req1.addr  : req0.addr;
  assign sel_wdata = (arb_gnt == PORT_AUX) ? req1.wdata : req0.wdata;

  // cnt counts completed READ cycles; this is the TIMEOUT-th READ cycle.
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = sel_we ? WRITE : READ;
      READ:    if (mem_ready || timeout_hit) state_nxt = RESP;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: strobes are decoded from state so reset kills them at once.
  always_comb begin
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    ack0         = 1'b0;
    ack1         = 1'b0;
    case (state)
      READ:  mem_read_en  = 1'b1;
      WRITE: mem_write_en = 1'b1;
      RESP: begin
        ack0 = (gnt == PORT_CPU);
        ack1 = (gnt == PORT_AUX);
      end
      default: ;
    endcase
  end

  assign req0.ack   = ack0;
  assign req0.rdata = ack0 ? rdata_q : '0;
  assign req0.err   = ack0 & err_q;
  assign req1.ack   = ack1;
  assign req1.rdata = ack1 ? rdata_q : '0;
  assign req1.err   = ack1 & err_q;

  // Grant, payload latch, timeout counter and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant  <= PORT_AUX;  // CPU wins the first contention
      gnt         <= PORT_CPU;
      mem_addr    <= '0;
      mem_data_in <= '0;
      cnt         <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_valid) begin
          gnt         <= arb_gnt;
          last_grant  <= arb_gnt;
          mem_addr    <= sel_addr;
          mem_data_in <= sel_wdata;
          cnt         <= '0;
        end
        READ: begin
          cnt <= cnt + 1'b1;
          if (mem_ready) begin       // ready beats a coincident timeout
            rdata_q <= mem_data_out;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        WRITE: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
